// File: rtl/chain_code_tx_scheduler_pkg.sv
// Shared constants, FSM states and packet layout for the chain-code TX scheduler.
package chain_code_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  ERR_BYTE  = 8'hEE;
    localparam int unsigned HDR_LEN   = 7;
    localparam int unsigned CODE_W    = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StHdr,
        StCodes,
        StCsum,
        StErr,
        StFinish
    } state_e;

    // Byte offsets of the header fields; offset 0 is the sync byte.
    localparam logic [2:0] OFF_SYNC    = 3'd0;
    localparam logic [2:0] OFF_X       = 3'd1;
    localparam logic [2:0] OFF_Y       = 3'd2;
    localparam logic [2:0] OFF_PER_HI  = 3'd3;
    localparam logic [2:0] OFF_PER_LO  = 3'd4;
    localparam logic [2:0] OFF_AREA_HI = 3'd5;
    localparam logic [2:0] OFF_AREA_LO = 3'd6;

    // Byte offsets within the error packet.
    localparam logic [2:0] OFF_ERR_CODE   = 3'd1;
    localparam logic [2:0] OFF_ERR_STATUS = 3'd2;

    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  off,
        input logic [5:0]  x,
        input logic [5:0]  y,
        input logic [8:0]  per,
        input logic [11:0] area
    );
        logic [7:0] b;
        case (off)
            OFF_X:       b = {2'b0, x};
            OFF_Y:       b = {2'b0, y};
            OFF_PER_HI:  b = {7'b0, per[8]};
            OFF_PER_LO:  b = per[7:0];
            OFF_AREA_HI: b = {4'b0, area[11:8]};
            OFF_AREA_LO: b = area[7:0];
            default:     b = SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/chain_code_tx_scheduler_if.sv
// Encoder and UART-side signals of the chain-code TX scheduler.
interface chain_code_tx_scheduler_if;

    logic        enc_start;
    logic        enc_done;
    logic [7:0]  enc_code;
    logic        enc_error;
    logic [8:0]  enc_perimeter;
    logic [11:0] enc_area;
    logic [5:0]  enc_start_x;
    logic [5:0]  enc_start_y;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output enc_start,
        input  enc_done,
        input  enc_code,
        input  enc_error,
        input  enc_perimeter,
        input  enc_area,
        input  enc_start_x,
        input  enc_start_y,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  enc_start,
        output enc_done,
        output enc_code,
        output enc_error,
        output enc_perimeter,
        output enc_area,
        output enc_start_x,
        output enc_start_y,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/chain_code_tx_scheduler_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two.
module chain_code_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/chain_code_tx_scheduler.sv
// Starts the chain-code encoder, buffers its code stream and frames it as a UART packet:
// sync, start point, perimeter, area, codes, checksum (or a short error packet on abort).
module chain_code_tx_scheduler
    import chain_code_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    output logic                      busy,
    output logic                      pkt_done,
    output logic                      overflow,
    output logic                      timeout,
    chain_code_tx_scheduler_if.master bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] HDR_LAST = OFF_AREA_LO;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic          last_q, last_d;
    logic          cap_q, cap_d;
    logic          ended_q, ended_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_ck_q, tx_ck_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;

    logic [5:0]    x_q;
    logic [5:0]    y_q;
    logic [8:0]    per_q;
    logic [11:0]   area_q;
    logic          err_q;
    logic          latch_en;

    logic              push;
    logic              pop;
    logic              fifo_clr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CODE_W-1:0] fifo_rdata;

    logic xfer;
    logic slot_free;
    logic unused_code_msbs;

    assign unused_code_msbs = ^bus.enc_code[7:3];

    chain_code_fifo #(
        .WIDTH(CODE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .clr  (fifo_clr),
        .push (push),
        .wdata(bus.enc_code[CODE_W-1:0]),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign xfer      = tx_valid_q && bus.tx_ready;
    // The output register may be refilled on the same edge its byte is accepted.
    assign slot_free = !tx_valid_q || bus.tx_ready;

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.enc_start = (state_q == StStart);
    assign busy          = (state_q != StIdle) && (state_q != StFinish);
    assign pkt_done      = (state_q == StFinish);
    assign overflow      = ovf_q;
    assign timeout       = tmo_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        last_d     = last_q;
        cap_d      = cap_q;
        ended_d    = ended_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_ck_d    = tx_ck_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        latch_en   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        fifo_clr   = 1'b0;

        if (xfer) begin
            tx_valid_d = 1'b0;
            if (tx_ck_q) begin
                csum_d = csum_q ^ tx_data_q;
            end
        end

        // Capture runs alongside HDR/CODES until the first fall of enc_done.
        if (cap_q) begin
            if (bus.enc_done) begin
                push = 1'b1;
            end else begin
                cap_d   = 1'b0;
                ended_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (go) begin
                    state_d  = StStart;
                    timer_d  = '0;
                    idx_d    = '0;
                    last_d   = 1'b0;
                    cap_d    = 1'b0;
                    ended_d  = 1'b0;
                    csum_d   = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b0;
                    fifo_clr = 1'b1;
                end
            end
            StStart: begin
                timer_d = timer_q + 1'b1;
                if (bus.enc_done) begin
                    latch_en   = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    tx_ck_d    = 1'b0;
                    idx_d      = OFF_X;
                    if (bus.enc_error) begin
                        state_d = StErr;
                    end else begin
                        state_d = StHdr;
                        cap_d   = 1'b1;
                        push    = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    tmo_d      = 1'b1;
                    state_d    = StErr;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    tx_ck_d    = 1'b0;
                    idx_d      = OFF_ERR_CODE;
                end
            end
            StHdr: begin
                if (slot_free) begin
                    tx_data_d  = hdr_byte(idx_q, x_q, y_q, per_q, area_q);
                    tx_valid_d = 1'b1;
                    tx_ck_d    = 1'b1;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == HDR_LAST) begin
                        state_d = StCodes;
                    end
                end
            end
            StCodes: begin
                if (slot_free) begin
                    if (!fifo_empty) begin
                        tx_data_d  = {{(8 - CODE_W){1'b0}}, fifo_rdata};
                        tx_valid_d = 1'b1;
                        tx_ck_d    = 1'b1;
                        pop        = 1'b1;
                    end else if (ended_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (!last_q) begin
                    if (slot_free) begin
                        // csum_d already folds in a byte accepted on this same edge.
                        tx_data_d  = csum_d;
                        tx_valid_d = 1'b1;
                        tx_ck_d    = 1'b0;
                        last_d     = 1'b1;
                    end
                end else if (xfer) begin
                    state_d = StFinish;
                end
            end
            StErr: begin
                if (!last_q) begin
                    if (slot_free) begin
                        tx_valid_d = 1'b1;
                        tx_ck_d    = 1'b0;
                        if (idx_q == OFF_ERR_CODE) begin
                            tx_data_d = ERR_BYTE;
                            idx_d     = OFF_ERR_STATUS;
                        end else begin
                            tx_data_d = {5'b0, tmo_q, ovf_q, err_q};
                            last_d    = 1'b1;
                        end
                    end
                end else if (xfer) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            cap_q      <= 1'b0;
            ended_q    <= 1'b0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_ck_q    <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            per_q      <= '0;
            area_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cap_q      <= cap_d;
            ended_q    <= ended_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_ck_q    <= tx_ck_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            if (latch_en) begin
                x_q    <= bus.enc_start_x;
                y_q    <= bus.enc_start_y;
                per_q  <= bus.enc_perimeter;
                area_q <= bus.enc_area;
                err_q  <= bus.enc_error;
            end
        end
    end

endmodule

// File: tb/tb_chain_code_tx_scheduler.sv
// Directed bench for chain_code_tx_scheduler: encoder stub, UART ready pattern, byte monitor.
module tb_chain_code_tx_scheduler;

    logic clk;
    logic reset;
    logic go;
    logic busy;
    logic pkt_done;
    logic overflow;
    logic timeout;

    chain_code_tx_scheduler_if bus ();

    chain_code_tx_scheduler #(
        .FIFO_DEPTH    (512),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .busy    (busy),
        .pkt_done(pkt_done),
        .overflow(overflow),
        .timeout (timeout),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic [7:0] exp_b[$];
    int cyc = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    int stall_bad = 0;
    int ready_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 0: always ready, 1: one cycle on / three off, 2: held off.
    initial begin
        int ph;
        ph = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.tx_ready = 1'b1;
                1: begin
                    bus.tx_ready = (ph == 0);
                    ph = (ph + 1) % 4;
                end
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // Transfers are judged at the negedge preceding the accepting posedge.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && !(bus.tx_valid && bus.tx_data == stall_data)) stall_bad++;
                if (bus.tx_valid && bus.tx_ready) begin
                    got.push_back(bus.tx_data);
                    last_xfer_cyc = cyc;
                end
                stall_prev = bus.tx_valid && !bus.tx_ready;
                stall_data = bus.tx_data;
                if (pkt_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.enc_start) start_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input int base);
        check({tag, "_len"}, got.size() - base, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (base + i < got.size()) ? {24'h0, got[base + i]} : 32'hFFFF_FFFF,
                  {24'h0, exp_b[i]});
        end
    endtask

    task automatic run_pkt(input logic [5:0] x, input logic [5:0] y, input logic [8:0] per,
                           input logic [11:0] area, input logic err, input int n,
                           input int mul, input int add);
        @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check("go_to_enc_start", bus.enc_start, 1);
        bus.enc_start_x   = x;
        bus.enc_start_y   = y;
        bus.enc_perimeter = per;
        bus.enc_area      = area;
        bus.enc_error     = err;
        for (int i = 0; i < n; i++) begin
            bus.enc_done = 1'b1;
            // Upper code bits are junk the DUT must ignore.
            bus.enc_code = 8'hF8 | 8'((mul * i + add) % 8);
            @(posedge clk);
            #1;
            if (i == 0) check("first_byte_sync", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA5});
        end
        bus.enc_done  = 1'b0;
        bus.enc_error = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_done_latency"}, done_cyc - last_xfer_cyc, 1);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int base;
        int d0;
        int s0;
        int sb0;
        int mism;

        reset             = 1'b1;
        go                = 1'b0;
        bus.enc_done      = 1'b0;
        bus.enc_code      = '0;
        bus.enc_error     = 1'b0;
        bus.enc_perimeter = '0;
        bus.enc_area      = '0;
        bus.enc_start_x   = '0;
        bus.enc_start_y   = '0;
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.tx_valid, bus.tx_data, bus.enc_start, busy, pkt_done, overflow, timeout}, 0);
        reset = 1'b1;

        // Normal packet; checksum = XOR of 05 09 00 04 00 0C 00 02 04 06 = 04.
        base = got.size();
        d0   = done_cnt;
        exp_b = '{8'hA5, 8'h05, 8'h09, 8'h00, 8'h04, 8'h00, 8'h0C,
                  8'h00, 8'h02, 8'h04, 8'h06, 8'h04};
        run_pkt(6'd5, 6'd9, 9'd4, 12'd12, 1'b0, 4, 2, 0);
        wait_done("normal", d0, 200);
        check_bytes("normal", base);
        check("normal_overflow", overflow, 0);

        // Backpressure: identical bytes, data held while stalled.
        ready_mode = 1;
        base = got.size();
        d0   = done_cnt;
        sb0  = stall_bad;
        run_pkt(6'd5, 6'd9, 9'd4, 12'd12, 1'b0, 4, 2, 0);
        wait_done("bp", d0, 400);
        check_bytes("bp", base);
        check("bp_data_stable", stall_bad - sb0, 0);
        check("bp_overflow", overflow, 0);
        ready_mode = 0;

        // Encoder error at first enc_done.
        base = got.size();
        d0   = done_cnt;
        exp_b = '{8'hA5, 8'hEE, 8'h01};
        run_pkt(6'd3, 6'd4, 9'd0, 12'd0, 1'b1, 1, 0, 0);
        wait_done("err", d0, 200);
        check_bytes("err", base);

        // Perimeter MSB: per=300 -> 01 2C; checksum 01^02^01^2C^03^45^01^03 = 6A.
        base = got.size();
        d0   = done_cnt;
        exp_b = '{8'hA5, 8'h01, 8'h02, 8'h01, 8'h2C, 8'h03, 8'h45, 8'h01, 8'h03, 8'h6A};
        run_pkt(6'd1, 6'd2, 9'd300, 12'h345, 1'b0, 2, 2, 1);
        wait_done("per9", d0, 200);
        check_bytes("per9", base);

        // Timeout: encoder silent.
        base = got.size();
        d0   = done_cnt;
        s0   = start_cnt;
        exp_b = '{8'hA5, 8'hEE, 8'h04};
        run_pkt(6'd0, 6'd0, 9'd0, 12'd0, 1'b0, 0, 0, 0);
        wait_done("tmo", d0, 300);
        check("tmo_start_cycles", start_cnt - s0, 64);
        check("tmo_flag", timeout, 1);
        check_bytes("tmo", base);

        // Overflow: 600 codes into 512 entries with the UART held off.
        ready_mode = 2;
        base = got.size();
        d0   = done_cnt;
        run_pkt(6'd7, 6'd8, 9'd100, 12'd50, 1'b0, 600, 1, 0);
        check("ovf_timeout_cleared", timeout, 0);
        check("ovf_flag_early", overflow, 1);
        repeat (400) @(posedge clk);
        #1;
        ready_mode = 0;
        wait_done("ovf", d0, 2000);
        check("ovf_flag", overflow, 1);
        check("ovf_len", got.size() - base, 7 + 512 + 1);
        mism = 0;
        for (int i = 0; i < 512; i++) begin
            if (base + 7 + i >= got.size() || got[base + 7 + i] !== 8'(i % 8)) mism++;
        end
        check("ovf_code_bytes", mism, 0);

        // Reset mid-CODES, then a clean packet.
        ready_mode = 1;
        base = got.size();
        run_pkt(6'd5, 6'd9, 9'd20, 12'd12, 1'b0, 20, 1, 0);
        for (int i = 0; i < 300 && got.size() < base + 9; i++) @(posedge clk);
        check("rst_reached_codes", got.size() >= base + 9, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs",
              {bus.tx_valid, bus.tx_data, bus.enc_start, busy, pkt_done, overflow, timeout}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ready_mode = 0;
        base = got.size();
        d0   = done_cnt;
        exp_b = '{8'hA5, 8'h05, 8'h09, 8'h00, 8'h04, 8'h00, 8'h0C,
                  8'h00, 8'h02, 8'h04, 8'h06, 8'h04};
        run_pkt(6'd5, 6'd9, 9'd4, 12'd12, 1'b0, 4, 2, 0);
        wait_done("post_rst", d0, 200);
        check_bytes("post_rst", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
